xbar_scheduler: RTL
===================

# xbar_scheduler

Flow-controlled scheduler around a 2x2 crossbar. Two valid/ready input streams each carry a data word and a 2-bit destination mask (out0, out1, or both). Each cycle the block picks a conflict-free set of transfers with round-robin fairness and drives the crossbar select. It captures the steered data into one output register per port. It sits between two producer lanes and two consumer lanes of the array and is the only writer of the crossbar select.

## Interface
- DATA_WIDTH, 8, data word width
- CNT_WIDTH, 16, stall counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in0_data / in1_data  in  DATA_WIDTH  input payloads
- in0_dest / in1_dest  in  2  bit0 = out0, bit1 = out1, 11 = broadcast
- in0_valid / in1_valid  in  1  request present
- in0_ready / in1_ready  out  1  beat accepted this cycle (combinational)
- out0_data / out1_data  out  DATA_WIDTH  registered output payloads
- out0_valid / out1_valid  out  1  output register holds a beat
- out0_ready / out1_ready  in  1  consumer takes the beat
- xbar_sel  out  2  select used in the last load cycle (00 thru, 01 cross, 10 bcast in0, 11 bcast in1)
- stall_cnt  out  CNT_WIDTH  saturating count of stall cycles
- err_dest  out  1  sticky flag, set when a zero-destination beat is consumed

## Operation
- Output k is free when !outk_valid || outk_ready.
- Priority pointer rr (0/1): input rr is evaluated first.
  - Higher-priority input: granted iff valid, dest != 00, and all dest outputs are free.
  - Lower-priority input: granted under the same rule, and its dest must also be disjoint from the granted input's dest.
- Broadcast (dest 11) is all-or-nothing. There is no partial delivery.
- dest == 00: input ready = 1 whenever valid, regardless of grants. The beat is discarded, err_dest is set, and no output is loaded.
- Select derivation for loaded outputs:
  - in0→out0 and/or in1→out1: 00
  - in1→out0 and/or in0→out1: 01
  - in0→both: 10
  - in1→both: 11
- With no grant, xbar_sel holds its value.
- Data is steered through the crossbar using the derived select. Only granted outputs load. Non-granted outputs keep their content, or clear valid if they were consumed.
- rr update: if both inputs are valid with nonzero dest and exactly one is granted, rr becomes the index of the loser. Otherwise rr is unchanged.
- Stall cycle: at least one input is valid with nonzero dest and is not granted. stall_cnt increments and saturates at all-ones.
- AXI-style rules: producers hold data and dest stable while valid && !ready. Consumers may drop ready at any time.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on outk_data/outk_valid after edge N.
- Full throughput: an output register consumed and reloaded in the same cycle sustains one beat per cycle per port.
- Simultaneous consume and load on the same port: the new beat replaces the old one, and valid stays 1.
- in*_ready depends combinationally on valid, dest, out*_ready and rr. No other path exists from out*_ready to any output.
- Reset values (on any edge with rst_n = 0, including mid-traffic): out*_valid 0, out*_data 0, rr 0, xbar_sel 00, stall_cnt 0, err_dest 0. Held beats are discarded.
- in*_ready is 0 while rst_n = 0.

## Structure
- Shared package xbar_pkg holds:
  - select codes SEL_THRU=00, SEL_CROSS=01, SEL_BC0=10, SEL_BC1=11
  - dest codes DEST_NONE=00, DEST_OUT0=01, DEST_OUT1=10, DEST_BOTH=11
- One sub-module: the existing Crossbar2x2, instantiated with DATA_WIDTH. The derived select drives its sel input. The output registers capture its out0/out1.
- Grant logic, rr, the output registers and the counters live in xbar_scheduler.

## Test plan
- in0 = 0xA1 dest 01 and in1 = 0xB2 dest 10, outputs ready → both ready, next cycle out0 = 0xA1, out1 = 0xB2, xbar_sel 00.
- in0 = 0x11 dest 10 and in1 = 0x22 dest 01 → both ready, out0 = 0x22, out1 = 0x11, xbar_sel 01.
- Both dest 01, rr = 0, continuous valid → grants alternate in0, in1, in0…, and stall_cnt increases by 1 per cycle.
- in1 = 0x5C dest 11 while out1 is full and out1_ready = 0 → in1_ready 0 and no partial load. When out1_ready is raised, out0 = out1 = 0x5C and xbar_sel 11.
- in0 dest 00 → in0_ready 1, no out valid, err_dest stays 1 until reset. Also drive stall_cnt to the ceiling with CNT_WIDTH = 4 and confirm it holds at 15.
- rst_n low for 1 cycle while both outputs are valid and stalled → all outputs, xbar_sel, stall_cnt and err_dest return to 0 on the next edge.

Source files
------------

// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared codes for the 2x2 crossbar scheduler slice.
//   sel_e       : crossbar select codes (thru, cross, broadcast in0/in1)
//   DEST_*      : 2-bit destination masks, bit0 = out0, bit1 = out1
// ---------------------------------------------------------------------------
package xbar_pkg;

   typedef enum logic [1:0] {
      SEL_THRU  = 2'b00,
      SEL_CROSS = 2'b01,
      SEL_BC0   = 2'b10,
      SEL_BC1   = 2'b11
   } sel_e;

   localparam logic [1:0] DEST_NONE = 2'b00;
   localparam logic [1:0] DEST_OUT0 = 2'b01;
   localparam logic [1:0] DEST_OUT1 = 2'b10;
   localparam logic [1:0] DEST_BOTH = 2'b11;

endpackage

// File: rtl/Crossbar2x2.sv
// ---------------------------------------------------------------------------
// Crossbar2x2
// Purely combinational 2x2 crossbar.
//   sel  in  2           00 thru, 01 cross, 10 in0 to both, 11 in1 to both
//   in0  in  DATA_WIDTH  lane 0 payload
//   in1  in  DATA_WIDTH  lane 1 payload
//   out0 out DATA_WIDTH  steered payload for port 0
//   out1 out DATA_WIDTH  steered payload for port 1
// ---------------------------------------------------------------------------
module Crossbar2x2
   import xbar_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [1:0]            sel,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   output logic [DATA_WIDTH-1:0] out0,
   output logic [DATA_WIDTH-1:0] out1
);

   always_comb begin
      out0 = in0;
      out1 = in1;
      case (sel)
         SEL_THRU:  begin out0 = in0; out1 = in1; end
         SEL_CROSS: begin out0 = in1; out1 = in0; end
         SEL_BC0:   begin out0 = in0; out1 = in0; end
         SEL_BC1:   begin out0 = in1; out1 = in1; end
         default:   begin out0 = in0; out1 = in1; end
      endcase
   end

endmodule

// File: rtl/xbar_scheduler.sv
// ---------------------------------------------------------------------------
// xbar_scheduler
// Round-robin, conflict-free scheduler in front of a 2x2 crossbar with one
// registered output slot per port.
//   clk, rst_n                 clock, synchronous active-low reset
//   in0_*/in1_*                valid/ready producer streams (data, dest mask)
//   in0_ready/in1_ready        combinational accept for the current beat
//   out0_*/out1_*              registered consumer streams
//   xbar_sel                   select applied in the most recent load cycle
//   stall_cnt                  saturating count of cycles with a refused request
//   err_dest                   sticky: a zero-destination beat was dropped
// ---------------------------------------------------------------------------
module xbar_scheduler
   import xbar_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [1:0]            in0_dest,
   input  logic                  in0_valid,
   output logic                  in0_ready,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic [1:0]            in1_dest,
   input  logic                  in1_valid,
   output logic                  in1_ready,
   output logic [DATA_WIDTH-1:0] out0_data,
   output logic                  out0_valid,
   input  logic                  out0_ready,
   output logic [DATA_WIDTH-1:0] out1_data,
   output logic                  out1_valid,
   input  logic                  out1_ready,
   output logic [1:0]            xbar_sel,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic                  err_dest
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   logic                  rr;
   logic [1:0]            free;
   logic                  req0, req1, fit0, fit1;
   logic                  gnt0, gnt1, any_gnt;
   logic                  drop0, drop1;
   logic                  ld0, ld1;
   logic                  stall, rr_flip;
   sel_e                  sel_new;
   logic [1:0]            sel_xb;
   logic [DATA_WIDTH-1:0] xb_out0, xb_out1;

   assign free[0] = !out0_valid || out0_ready;
   assign free[1] = !out1_valid || out1_ready;

   assign req0  = in0_valid && (in0_dest != DEST_NONE);
   assign req1  = in1_valid && (in1_dest != DEST_NONE);
   // every requested port must be free: broadcast is all-or-nothing
   assign fit0  = (in0_dest & ~free) == 2'b00;
   assign fit1  = (in1_dest & ~free) == 2'b00;
   assign drop0 = in0_valid && (in0_dest == DEST_NONE);
   assign drop1 = in1_valid && (in1_dest == DEST_NONE);

   // priority side grants on its own; the other side must not overlap it
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rr) begin
         gnt0 = req0 && fit0;
         gnt1 = req1 && fit1 && !(gnt0 && ((in0_dest & in1_dest) != 2'b00));
      end else begin
         gnt1 = req1 && fit1;
         gnt0 = req0 && fit0 && !(gnt1 && ((in0_dest & in1_dest) != 2'b00));
      end
   end

   assign any_gnt = gnt0 || gnt1;
   assign in0_ready = rst_n && (gnt0 || drop0);
   assign in1_ready = rst_n && (gnt1 || drop1);

   // when both are granted their dests are complementary single ports, so
   // the first granted lane alone decides thru versus cross
   always_comb begin
      sel_new = SEL_THRU;
      if (gnt0 && in0_dest == DEST_BOTH)
         sel_new = SEL_BC0;
      else if (gnt1 && in1_dest == DEST_BOTH)
         sel_new = SEL_BC1;
      else if (gnt0)
         sel_new = (in0_dest == DEST_OUT0) ? SEL_THRU : SEL_CROSS;
      else if (gnt1)
         sel_new = (in1_dest == DEST_OUT1) ? SEL_THRU : SEL_CROSS;
   end

   assign sel_xb = any_gnt ? sel_new : xbar_sel;

   assign ld0 = (gnt0 && in0_dest[0]) || (gnt1 && in1_dest[0]);
   assign ld1 = (gnt0 && in0_dest[1]) || (gnt1 && in1_dest[1]);

   assign stall   = (req0 && !gnt0) || (req1 && !gnt1);
   // exactly one winner of a real contest: loser gets priority next time
   assign rr_flip = req0 && req1 && (gnt0 != gnt1);

   Crossbar2x2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_xbar (
      .sel  (sel_xb),
      .in0  (in0_data),
      .in1  (in1_data),
      .out0 (xb_out0),
      .out1 (xb_out1)
   );

   // ---- output register stage ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out0_data  <= '0;
         out0_valid <= 1'b0;
         out1_data  <= '0;
         out1_valid <= 1'b0;
         xbar_sel   <= SEL_THRU;
         rr         <= 1'b0;
         stall_cnt  <= '0;
         err_dest   <= 1'b0;
      end else begin
         if (ld0) begin
            out0_data  <= xb_out0;
            out0_valid <= 1'b1;
         end else if (out0_ready) begin
            out0_valid <= 1'b0;
         end
         if (ld1) begin
            out1_data  <= xb_out1;
            out1_valid <= 1'b1;
         end else if (out1_ready) begin
            out1_valid <= 1'b0;
         end
         if (any_gnt)
            xbar_sel <= sel_new;
         if (rr_flip)
            rr <= gnt0;
         if (stall)
            stall_cnt <= sat_inc(stall_cnt);
         if (drop0 || drop1)
            err_dest <= 1'b1;
      end
   end

endmodule
